// File: rtl/systolic_ctrl_if.sv
// Host/buffer/array-side signals of the systolic array sequencer.
// The slave modport is the sequencer's view; master is the host/environment view.
interface systolic_ctrl_if #(
  parameter int N     = 2,
  parameter int WIDTH = 8,
  parameter int KW    = 8
);
  logic                 start;
  logic                 abort;
  logic [KW-1:0]        k_len;
  logic                 rd_en;
  logic [KW-1:0]        rd_k;
  logic [N*WIDTH-1:0]   a_col;
  logic [N*WIDTH-1:0]   b_row;
  logic [N*WIDTH-1:0]   a_west;
  logic [N-1:0]         valid_west;
  logic [N*WIDTH-1:0]   b_north;
  logic [N-1:0]         valid_north;
  logic                 array_rst;
  logic                 busy;
  logic                 done;

  modport slave (
    input  start, abort, k_len, a_col, b_row,
    output rd_en, rd_k, a_west, valid_west, b_north, valid_north,
           array_rst, busy, done
  );

  modport master (
    output start, abort, k_len, a_col, b_row,
    input  rd_en, rd_k, a_west, valid_west, b_north, valid_north,
           array_rst, busy, done
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN output-stationary systolic MAC array: clears the array,
// streams k_len operand columns/rows with per-lane skew, drains, pulses done.
module systolic_ctrl #(
  parameter int N     = 2,
  parameter int WIDTH = 8,
  parameter int KW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  systolic_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2 * N - 1);

  state_t          state;
  logic [KW-1:0]   k_lat;
  logic [CW-1:0]   drain_cnt;
  logic            rd_en;
  logic [KW-1:0]   rd_k;
  logic            array_rst;
  logic            busy;
  logic            done;
  logic            abort_cut;

  logic [N*WIDTH-1:0] a_west_q;
  logic [N*WIDTH-1:0] b_north_q;
  logic [N-1:0]       valid_west_q;
  logic [N-1:0]       valid_north_q;

  assign abort_cut = bus.abort && (state inside {S_CLEAR, S_FEED, S_DRAIN});

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k_lat     <= '0;
      drain_cnt <= '0;
      rd_en     <= 1'b0;
      rd_k      <= '0;
      array_rst <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort_cut) begin
      state     <= S_IDLE;
      rd_en     <= 1'b0;
      array_rst <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            k_lat     <= bus.k_len;
            array_rst <= 1'b1;
            busy      <= 1'b1;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          array_rst <= 1'b0;
          if (k_lat != '0) begin
            rd_en <= 1'b1;
            rd_k  <= '0;
            state <= S_FEED;
          end else begin
            drain_cnt <= DRAIN_LAST;
            state     <= S_DRAIN;
          end
        end
        S_FEED: begin
          if (rd_k == k_lat - KW'(1)) begin
            rd_en     <= 1'b0;
            drain_cnt <= DRAIN_LAST;
            state     <= S_DRAIN;
          end else begin
            rd_k <= rd_k + KW'(1);
          end
        end
        S_DRAIN: begin
          // 2N cycles lets the last operand cross the whole array diagonal.
          if (drain_cnt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            drain_cnt <= drain_cnt - CW'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Lane i: data delayed i+1 stages behind the buffer output, valid delayed
  // i+2 stages behind rd_en (one extra for the buffer read latency).
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [WIDTH-1:0] a_pipe [i+1];
    logic [WIDTH-1:0] b_pipe [i+1];
    logic [i+1:0]     va_pipe;
    logic [i+1:0]     vb_pipe;

    // NOTE: the skew storage is reset explicitly because the outputs must
    // read zero after reset; plain data pipes would not otherwise need it.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s <= i; s++) begin
          a_pipe[s] <= '0;
          b_pipe[s] <= '0;
        end
      end else begin
        a_pipe[0] <= bus.a_col[i*WIDTH +: WIDTH];
        b_pipe[0] <= bus.b_row[i*WIDTH +: WIDTH];
        for (int s = 1; s <= i; s++) begin
          a_pipe[s] <= a_pipe[s-1];
          b_pipe[s] <= b_pipe[s-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst || abort_cut) begin
        va_pipe <= '0;
        vb_pipe <= '0;
      end else begin
        va_pipe <= {va_pipe[i:0], rd_en};
        vb_pipe <= {vb_pipe[i:0], rd_en};
      end
    end

    assign a_west_q[i*WIDTH +: WIDTH]  = a_pipe[i];
    assign b_north_q[i*WIDTH +: WIDTH] = b_pipe[i];
    assign valid_west_q[i]             = va_pipe[i+1];
    assign valid_north_q[i]            = vb_pipe[i+1];
  end

  assign bus.rd_en       = rd_en;
  assign bus.rd_k        = rd_k;
  assign bus.array_rst   = array_rst;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.a_west      = a_west_q;
  assign bus.b_north     = b_north_q;
  assign bus.valid_west  = valid_west_q;
  assign bus.valid_north = valid_north_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: control-trace and operand scoreboards,
// a one-cycle-latency operand buffer and a behavioural PE array.
module tb_systolic_ctrl;
  localparam int N     = 2;
  localparam int WIDTH = 8;
  localparam int KW    = 8;

  typedef struct packed {
    logic          array_rst;
    logic          rd_en;
    logic [KW-1:0] rd_k;
    logic [N-1:0]  vw;
    logic [N-1:0]  vn;
    logic          busy;
    logic          done;
  } ctl_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  systolic_ctrl_if #(.N(N), .WIDTH(WIDTH), .KW(KW)) bus ();
  systolic_ctrl #(.N(N), .WIDTH(WIDTH), .KW(KW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  ctl_t             ctl_q [$];
  logic [WIDTH-1:0] a_q [N][$];
  logic [WIDTH-1:0] b_q [N][$];
  logic [WIDTH-1:0] mem_a [256][N];
  logic [WIDTH-1:0] mem_b [256][N];
  logic [KW-1:0]    exp_rdk = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle control trace, c = 0 is the cycle start is sampled.
  task automatic push_run(input int k);
    ctl_t e;
    for (int c = 0; c <= k + 2*N + 2; c++) begin
      e.array_rst = (c == 1);
      e.rd_en     = (c >= 2) && (c <= k + 1);
      if (e.rd_en) exp_rdk = KW'(c - 2);
      e.rd_k      = exp_rdk;
      for (int i = 0; i < N; i++) e.vw[i] = (c - i - 2 >= 2) && (c - i - 2 <= k + 1);
      e.vn        = e.vw;
      e.busy      = (c >= 1) && (c <= k + 2*N + 1);
      e.done      = (c == k + 2*N + 2);
      ctl_q.push_back(e);
    end
  endtask

  // Operand buffer: one-cycle read latency, junk when not reading.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus.rd_en === 1'b1) begin
        bus.a_col[i*WIDTH +: WIDTH] <= mem_a[bus.rd_k][i];
        bus.b_row[i*WIDTH +: WIDTH] <= mem_b[bus.rd_k][i];
        a_q[i].push_back(mem_a[bus.rd_k][i]);
        b_q[i].push_back(mem_b[bus.rd_k][i]);
      end else begin
        bus.a_col[i*WIDTH +: WIDTH] <= WIDTH'($urandom);
        bus.b_row[i*WIDTH +: WIDTH] <= WIDTH'($urandom);
      end
    end
  end

  // Behavioural output-stationary PE array.
  logic [WIDTH-1:0] pe_a [N][N];
  logic [WIDTH-1:0] pe_b [N][N];
  logic             pe_va [N][N];
  logic             pe_vb [N][N];
  int unsigned      acc [N][N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic [WIDTH-1:0] ai, bi;
        logic vai, vbi;
        if (j == 0) begin
          ai = bus.a_west[i*WIDTH +: WIDTH]; vai = bus.valid_west[i];
        end else begin
          ai = pe_a[i][j-1]; vai = pe_va[i][j-1];
        end
        if (i == 0) begin
          bi = bus.b_north[j*WIDTH +: WIDTH]; vbi = bus.valid_north[j];
        end else begin
          bi = pe_b[i-1][j]; vbi = pe_vb[i-1][j];
        end
        if (rst || bus.array_rst) begin
          acc[i][j] <= 0; pe_va[i][j] <= 1'b0; pe_vb[i][j] <= 1'b0;
        end else begin
          if (vai === 1'b1 && vbi === 1'b1) acc[i][j] <= acc[i][j] + 32'(ai) * 32'(bi);
          pe_va[i][j] <= vai; pe_vb[i][j] <= vbi;
        end
        pe_a[i][j] <= ai; pe_b[i][j] <= bi;
      end
    end
  end

  // Scoreboard pop/compare, away from the active edge.
  always @(negedge clk) begin
    ctl_t e;
    if (ctl_q.size() > 0) begin
      e = ctl_q.pop_front();
      check("array_rst", bus.array_rst, e.array_rst);
      check("rd_en", bus.rd_en, e.rd_en);
      check("rd_k", bus.rd_k, e.rd_k);
      check("valid_west", bus.valid_west, e.vw);
      check("valid_north", bus.valid_north, e.vn);
      check("busy", bus.busy, e.busy);
      check("done", bus.done, e.done);
    end
    for (int i = 0; i < N; i++) begin
      if (bus.valid_west[i] === 1'b1) begin
        check($sformatf("a_q_nonempty[%0d]", i), 64'(a_q[i].size() != 0), 1);
        if (a_q[i].size() != 0)
          check($sformatf("a_west[%0d]", i), bus.a_west[i*WIDTH +: WIDTH], a_q[i].pop_front());
      end
      if (bus.valid_north[i] === 1'b1) begin
        check($sformatf("b_q_nonempty[%0d]", i), 64'(b_q[i].size() != 0), 1);
        if (b_q[i].size() != 0)
          check($sformatf("b_north[%0d]", i), bus.b_north[i*WIDTH +: WIDTH], b_q[i].pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush_data();
    for (int i = 0; i < N; i++) begin
      a_q[i].delete();
      b_q[i].delete();
    end
  endtask

  // Drive start (optionally with abort) for one cycle; returns in cycle S+1.
  task automatic run(input int k, input bit with_abort);
    step(1);
    bus.start = 1'b1; bus.k_len = KW'(k); bus.abort = with_abort;
    push_run(k);
    step(1);
    bus.start = 1'b0; bus.abort = 1'b0; bus.k_len = KW'($urandom);
  endtask

  // From cycle S+1, advance to the done cycle and check completion.
  task automatic finish_run(input int k, input string tag);
    step(k + 2*N + 1);
    check({tag, "_done"}, bus.done, 1'b1);
    for (int i = 0; i < N; i++) begin
      check({tag, "_a_q_drained"}, a_q[i].size(), 0);
      check({tag, "_b_q_drained"}, b_q[i].size(), 0);
    end
    step(1);
    check({tag, "_idle_busy"}, bus.busy, 1'b0);
    check({tag, "_idle_done"}, bus.done, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, bus.rd_en, 1'b0);
    check({tag, "_rd_k"}, bus.rd_k, '0);
    check({tag, "_a_west"}, bus.a_west, '0);
    check({tag, "_b_north"}, bus.b_north, '0);
    check({tag, "_valid_west"}, bus.valid_west, '0);
    check({tag, "_valid_north"}, bus.valid_north, '0);
    check({tag, "_array_rst"}, bus.array_rst, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_done"}, bus.done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.k_len = '0;
    for (int k = 0; k < 256; k++)
      for (int i = 0; i < N; i++) begin
        mem_a[k][i] = WIDTH'($urandom);
        mem_b[k][i] = WIDTH'($urandom);
      end

    step(2);
    check_reset_outputs("reset");
    rst = 1'b0;
    step(1);

    // k_len=3: trace plus skewed data scoreboard.
    run(3, 1'b0);
    finish_run(3, "k3");

    // Full multiply A=[[1,2],[3,4]], B=[[5,6],[7,8]].
    mem_a[0][0] = 8'd1; mem_a[0][1] = 8'd3; mem_a[1][0] = 8'd2; mem_a[1][1] = 8'd4;
    mem_b[0][0] = 8'd5; mem_b[0][1] = 8'd6; mem_b[1][0] = 8'd7; mem_b[1][1] = 8'd8;
    run(2, 1'b0);
    step(2*N + 3);
    check("mm_done", bus.done, 1'b1);
    check("c00", acc[0][0], 19);
    check("c01", acc[0][1], 22);
    check("c10", acc[1][0], 43);
    check("c11", acc[1][1], 50);
    step(1);

    // k_len=0: no reads, done in cycle 6, accumulators cleared.
    run(0, 1'b0);
    step(2*N + 1);
    check("k0_done", bus.done, 1'b1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("k0_c%0d%0d", i, j), acc[i][j], 0);
    step(1);

    // start and abort together in IDLE: start wins.
    run(1, 1'b1);
    finish_run(1, "start_abort");

    // start held high: back-to-back runs, k_len change mid-run has no effect.
    step(1);
    bus.start = 1'b1; bus.k_len = KW'(1);
    push_run(1); push_run(1);
    step(10);
    bus.k_len = KW'(5);
    step(2);
    bus.start = 1'b0;
    step(3);
    check("held_second_done", bus.done, 1'b1);
    step(1);
    check("held_idle_busy", bus.busy, 1'b0);
    step(1);
    check("held_no_third_run", bus.busy, 1'b0);
    check("held_no_third_clear", bus.array_rst, 1'b0);

    // abort in the second DRAIN cycle (k_len=2: DRAIN is S+4..S+7).
    step(1);
    bus.start = 1'b1; bus.k_len = KW'(2);
    step(1);
    bus.start = 1'b0;
    step(4);
    check("abort_pre_busy", bus.busy, 1'b1);
    bus.abort = 1'b1;
    step(1);
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_rd_en", bus.rd_en, 1'b0);
    for (int c = 0; c < 8; c++) begin
      check("abort_valid_west", bus.valid_west, '0);
      check("abort_valid_north", bus.valid_north, '0);
      check("abort_no_done", bus.done, 1'b0);
      step(1);
    end
    flush_data();
    exp_rdk = KW'(1);

    // Reset asserted mid-FEED, then a clean run proves IDLE.
    step(1);
    bus.start = 1'b1; bus.k_len = KW'(4);
    step(1);
    bus.start = 1'b0;
    step(2);
    check("midfeed_rd_en", bus.rd_en, 1'b1);
    rst = 1'b1;
    step(1);
    check_reset_outputs("midfeed_rst");
    rst = 1'b0;
    flush_data();
    exp_rdk = '0;
    run(2, 1'b0);
    finish_run(2, "after_rst");

    check("ctl_q_drained", ctl_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
